cgra_ctx_seq: RTL and testbench
===============================

Name: cgra_ctx_seq

Overview:
Per-PE context sequencer sitting directly upstream of the CGRA processing element. It holds a small context memory of 64-bit configuration frames and replays a programmed window of them onto the PE's config_frame/config_valid inputs. Replay runs in order, optionally repeated a programmed number of iterations, with stall and abort control. A host/loader writes frames while the sequencer is idle; a controller starts a run and waits for done.

Parameters:
CTX_DEPTH, 16, number of context frames stored
CTX_AW, 4, context address width (log2 CTX_DEPTH)
LOOP_W, 8, width of the iteration counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_we  in  1  context write strobe (accepted only when busy=0)
cfg_waddr  in  CTX_AW  context write address
cfg_wdata  in  64  frame to store (PE frame format: op[5:0], src0[9:6], src1[13:10], dst[17:14], route[21:18], pred_en[22], pred_inv[23], imm[39:24], ext[63:40])
start  in  1  begin a run (sampled only when busy=0)
ctx_len  in  CTX_AW+1  frames per iteration; legal 1..CTX_DEPTH
loop_cnt  in  LOOP_W  iterations; 0 is treated as 1
stall  in  1  downstream hold; suppresses issue this cycle
abort  in  1  terminate a run
config_frame  out  64  frame presented to the PE
config_valid  out  1  frame is to be executed this cycle
cur_idx  out  CTX_AW  context index of the frame on config_frame
busy  out  1  run in progress
done  out  1  one-cycle completion pulse
err  out  1  sticky error (parity build only; 0 otherwise)

Behaviour:
- Reset (async assert, sync deassert by clock): config_frame=0 (NOP), config_valid=0, cur_idx=0, busy=0, done=0, err=0, state IDLE, counters cleared. Context memory is not reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_we writes mem[cfg_waddr]<=cfg_wdata.
  - If start=1 and 1<=ctx_len<=CTX_DEPTH: latch len and iterations (max(loop_cnt,1)), set idx=0, iter=0, go to RUN.
  - start with illegal ctx_len is ignored.
- RUN:
  - busy=1. cfg_we and start are ignored.
  - On each edge with stall=0: config_frame<=mem[idx], cur_idx<=idx, config_valid<=1, idx advances.
  - On each edge with stall=1: config_valid<=0; config_frame and cur_idx hold; idx holds.
  - Wrap: when idx==len-1 is issued, idx<=0 and iter++.
  - Issuing the last frame of the last iteration moves the state to DONE.
- Latency: start sampled at edge k gives the first config_valid=1 in the cycle after edge k+1 (one bubble). Back-to-back issue thereafter with no bubbles at iteration wrap.
- DONE: config_valid=0, done=1 for exactly one cycle, busy=0 in that cycle; next edge returns to IDLE. done is asserted in the cycle immediately after the last config_valid=1 cycle.
- abort (RUN or DONE): next edge forces IDLE, config_valid=0, busy=0. No done pulse. config_frame holds its last value. abort in IDLE has no effect.
- Simultaneous stall and abort: abort wins.
- Exactly len×iterations frames issue per run, never duplicated or skipped under any stall pattern.
- Iteration counter is LOOP_W bits; loop_cnt=2^LOOP_W-1 must complete without overflow.

Optional Feature:
- Macro: CGRA_CTX_PARITY_EN.
- When defined:
  - Each context entry stores an extra even-parity bit computed on write.
  - On an issue attempt whose read parity mismatches: the frame is not issued (config_valid=0), err<=1, the state goes to IDLE with no done pulse.
  - err is sticky and clears only on an accepted start.
- When undefined: no parity storage or check, and err is tied to 0.

Decomposition:
- Shared package cgra_pkg: CFG_W=64, frame field bit positions, PE opcode constants (NOP=0, ADD=1, SUB=2, MUL=3, MAC=4, PASS0=16, LIF=18, ...), and the state enum ctx_seq_state_t {IDLE,RUN,DONE}.
- Sub-module cgra_ctx_mem: CTX_DEPTH×(64 + optional parity bit) array with one synchronous write port and one combinational read port, and the parity generate/check inside it.

Test Plan:
1. Write frames F0=0x..01 (ADD), F1=0x..03 (MUL), F2=0x..10 (PASS0); start, len=3, loop=1, no stall → config_valid high 3 consecutive cycles from the cycle after start+1; frames F0,F1,F2 with cur_idx 0,1,2; done pulses next cycle; busy=0 thereafter.
2. len=2, loop=3 → F0,F1,F0,F1,F0,F1 with no bubbles, then one done pulse. Repeat with loop=0 → F0,F1 only.
3. len=3, loop=1, stall=1 for 2 cycles after F0 issues → config_valid low 2 cycles, config_frame holds F0, then F1,F2 issue; 3 frames total, no duplicate.
4. Mid-run abort after F1 → config_valid=0 next cycle, no done, busy=0. cfg_we to addr 0 during the run is ignored: a rerun still shows the original F0. start with ctx_len=0 or 17 → busy stays 0.
5. rst_n pulled low between clock edges mid-run → config_valid, busy and config_frame go to 0 immediately without a clock edge; after release, a new start runs normally.
6. (CGRA_CTX_PARITY_EN) Deposit a single-bit flip into entry 1, run len=3 → F0 issues, F1 does not, err=1, busy=0, no done; the next start clears err.

Source files
------------

// File: rtl/cgra_pkg.sv
// ----------------------------------------------------------------------------
// cgra_pkg
// Shared definitions for the CGRA processing-element configuration path:
// frame width, frame field bit positions, PE opcode constants, the context
// sequencer state type and the frame parity helper.
// ----------------------------------------------------------------------------
package cgra_pkg;

    localparam int CFG_W = 64;

    // Frame field bit positions (LSB / MSB inclusive)
    localparam int OP_LSB       = 0;
    localparam int OP_MSB       = 5;
    localparam int SRC0_LSB     = 6;
    localparam int SRC0_MSB     = 9;
    localparam int SRC1_LSB     = 10;
    localparam int SRC1_MSB     = 13;
    localparam int DST_LSB      = 14;
    localparam int DST_MSB      = 17;
    localparam int ROUTE_LSB    = 18;
    localparam int ROUTE_MSB    = 21;
    localparam int PRED_EN_BIT  = 22;
    localparam int PRED_INV_BIT = 23;
    localparam int IMM_LSB      = 24;
    localparam int IMM_MSB      = 39;
    localparam int EXT_LSB      = 40;
    localparam int EXT_MSB      = 63;

    // PE opcodes
    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_MUL   = 6'd3;
    localparam logic [5:0] OP_MAC   = 6'd4;
    localparam logic [5:0] OP_PASS0 = 6'd16;
    localparam logic [5:0] OP_LIF   = 6'd18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctx_seq_state_t;

    // Even-parity bit: makes the total number of ones (frame + bit) even.
    function automatic logic frame_parity(input logic [CFG_W-1:0] frame);
        return ^frame;
    endfunction

endpackage

// File: rtl/cgra_ctx_mem.sv
// ----------------------------------------------------------------------------
// cgra_ctx_mem
// Context frame store: CTX_DEPTH entries, one synchronous write port and one
// combinational read port. Contents are not reset.
// Build option CGRA_CTX_PARITY_EN: each entry carries an even-parity bit
// generated on write; perr flags a parity mismatch on the read port.
// Without the option no parity is stored and perr is 0.
//
// Ports:
//   clk    in   clock
//   we     in   write strobe
//   waddr  in   write address
//   wdata  in   frame to store
//   raddr  in   read address
//   rdata  out  frame at raddr
//   perr   out  parity mismatch on the entry at raddr
// ----------------------------------------------------------------------------
module cgra_ctx_mem
    import cgra_pkg::*;
#(
    parameter int CTX_DEPTH = 16,
    parameter int CTX_AW    = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [CTX_AW-1:0] waddr,
    input  logic [CFG_W-1:0]  wdata,
    input  logic [CTX_AW-1:0] raddr,
    output logic [CFG_W-1:0]  rdata,
    output logic              perr
);

`ifdef CGRA_CTX_PARITY_EN
    logic [CFG_W:0] mem_q [CTX_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= {frame_parity(wdata), wdata};
        end
    end

    assign rdata = mem_q[raddr][CFG_W-1:0];
    // Stored word including its parity bit must have an even number of ones.
    assign perr  = ^mem_q[raddr];
`else
    logic [CFG_W-1:0] mem_q [CTX_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
    assign perr  = 1'b0;
`endif

endmodule

// File: rtl/cgra_ctx_seq.sv
// ----------------------------------------------------------------------------
// cgra_ctx_seq
// Per-PE context sequencer. Holds CTX_DEPTH configuration frames and replays
// frames 0..len-1 onto the PE, repeated for a programmed number of
// iterations, with stall and abort control. Frames are loaded while idle.
// Build option CGRA_CTX_PARITY_EN enables per-entry parity checking; a
// corrupted entry stops the run and raises the sticky err flag.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   cfg_we/waddr/wdata   context write (accepted only while idle)
//   start, ctx_len, loop_cnt   run request (sampled only while idle)
//   stall          suppress issue this cycle
//   abort          terminate the current run without a done pulse
//   config_frame   frame presented to the PE (holds when not issuing)
//   config_valid   frame is to be executed this cycle
//   cur_idx        context index of config_frame
//   busy           run in progress
//   done           one-cycle completion pulse
//   err            sticky parity error (always 0 without the parity build)
// ----------------------------------------------------------------------------
module cgra_ctx_seq
    import cgra_pkg::*;
#(
    parameter int CTX_DEPTH = 16,
    parameter int CTX_AW    = 4,
    parameter int LOOP_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CTX_AW-1:0] cfg_waddr,
    input  logic [CFG_W-1:0]  cfg_wdata,
    input  logic              start,
    input  logic [CTX_AW:0]   ctx_len,
    input  logic [LOOP_W-1:0] loop_cnt,
    input  logic              stall,
    input  logic              abort,
    output logic [CFG_W-1:0]  config_frame,
    output logic              config_valid,
    output logic [CTX_AW-1:0] cur_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CTX_AW:0] MAX_LEN = (CTX_AW+1)'(CTX_DEPTH);

    ctx_seq_state_t    state_q, state_d;
    logic [CTX_AW-1:0] idx_q, idx_d;
    logic [LOOP_W-1:0] iter_q, iter_d;
    logic [CTX_AW:0]   len_q, len_d;
    logic [LOOP_W-1:0] iters_q, iters_d;
    logic [CFG_W-1:0]  frame_q, frame_d;
    logic              valid_q, valid_d;
    logic [CTX_AW-1:0] cur_idx_q, cur_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic [CFG_W-1:0]  rd_frame;
    logic              rd_perr;
    logic              len_ok;
    logic              last_in_iter;
    logic              last_iter;

    assign mem_we = cfg_we && (state_q == IDLE);

    cgra_ctx_mem #(
        .CTX_DEPTH (CTX_DEPTH),
        .CTX_AW    (CTX_AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (cfg_waddr),
        .wdata (cfg_wdata),
        .raddr (idx_q),
        .rdata (rd_frame),
        .perr  (rd_perr)
    );

    assign len_ok       = (ctx_len != '0) && (ctx_len <= MAX_LEN);
    assign last_in_iter = ({1'b0, idx_q} == (len_q - 1'b1));
    assign last_iter    = (iter_q == (iters_q - 1'b1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        iter_d    = iter_q;
        len_d     = len_q;
        iters_d   = iters_q;
        frame_d   = frame_q;
        valid_d   = valid_q;
        cur_idx_d = cur_idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (start && len_ok) begin
                    len_d   = ctx_len;
                    iters_d = (loop_cnt == '0) ? LOOP_W'(1) : loop_cnt;
                    idx_d   = '0;
                    iter_d  = '0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end

            RUN: begin
                if (abort) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (stall) begin
                    valid_d = 1'b0;
                end else if (rd_perr) begin
                    // Corrupted entry: drop the frame and end the run quietly.
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    frame_d   = rd_frame;
                    cur_idx_d = idx_q;
                    valid_d   = 1'b1;
                    if (last_in_iter) begin
                        idx_d  = '0;
                        iter_d = iter_q + 1'b1;
                        // Outputs are registered, so DONE is the cycle that
                        // presents the final frame; done pulses one cycle later.
                        if (last_iter) begin
                            state_d = DONE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            DONE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = !abort;
                state_d = IDLE;
            end

            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            iter_q    <= '0;
            len_q     <= '0;
            iters_q   <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            cur_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            iter_q    <= iter_d;
            len_q     <= len_d;
            iters_q   <= iters_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            cur_idx_q <= cur_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign config_frame = frame_q;
    assign config_valid = valid_q;
    assign cur_idx      = cur_idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_cgra_ctx_seq.sv
// ----------------------------------------------------------------------------
// tb_cgra_ctx_seq
// Self-checking bench for cgra_ctx_seq: table of run requests with expected
// frame counts, hand-written stall / abort / reset / parity sequences, and
// randomized runs checked against a queue-based frame-order model.
// ----------------------------------------------------------------------------
module tb_cgra_ctx_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_waddr;
    logic [63:0] cfg_wdata;
    logic        start;
    logic [4:0]  ctx_len;
    logic [7:0]  loop_cnt;
    logic        stall;
    logic        abort;
    logic [63:0] config_frame;
    logic        config_valid;
    logic [3:0]  cur_idx;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] shadow [16];
    logic [63:0] exp_frame;
    logic [3:0]  exp_idx;

    cgra_ctx_seq #(
        .CTX_DEPTH (16),
        .CTX_AW    (4),
        .LOOP_W    (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_waddr    (cfg_waddr),
        .cfg_wdata    (cfg_wdata),
        .start        (start),
        .ctx_len      (ctx_len),
        .loop_cnt     (loop_cnt),
        .stall        (stall),
        .abort        (abort),
        .config_frame (config_frame),
        .config_valid (config_valid),
        .cur_idx      (cur_idx),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [63:0] d);
        cfg_we    = 1'b1;
        cfg_waddr = 4'(a);
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
        shadow[a] = d;
    endtask

    // Randomized-stall run checked against the list of context indices the
    // run must produce: len indices per iteration, max(loop,1) iterations.
    task automatic run_model(input int len, input int loop, input int stall_pct, input int abort_at);
        int q[$];
        int iters;
        int issued;
        int stalls;
        int e;
        logic s;
        iters = (loop == 0) ? 1 : loop;
        for (int it = 0; it < iters; it++)
            for (int i = 0; i < len; i++)
                q.push_back(i);
        ctx_len  = 5'(len);
        loop_cnt = 8'(loop);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        chk("m_busy_start", busy, 1);
        chk("m_bubble", config_valid, 0);
        issued = 0;
        stalls = 0;
        while (q.size() > 0) begin
            s = (($urandom_range(0, 99) < stall_pct) && (stalls < 200)) ? 1'b1 : 1'b0;
            if (s) stalls++;
            stall = s;
            if (issued == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                stall = 1'b0;
                chk("m_abort_valid", config_valid, 0);
                chk("m_abort_busy", busy, 0);
                chk("m_abort_done", done, 0);
                chk("m_abort_frame", config_frame, exp_frame);
                tick();
                chk("m_abort_nodone", done, 0);
                chk("m_abort_idle", busy, 0);
                return;
            end
            tick();
            if (!s) begin
                e = q.pop_front();
                exp_frame = shadow[e];
                exp_idx   = 4'(e);
                issued++;
                chk("m_valid", config_valid, 1);
            end else begin
                chk("m_stall_valid", config_valid, 0);
            end
            chk("m_frame", config_frame, exp_frame);
            chk("m_idx", cur_idx, exp_idx);
            chk("m_busy", busy, 1);
            chk("m_done_early", done, 0);
        end
        stall = 1'(($urandom_range(0, 1)));
        tick();
        stall = 1'b0;
        chk("m_done", done, 1);
        chk("m_done_busy", busy, 0);
        chk("m_done_valid", config_valid, 0);
        chk("m_done_frame", config_frame, exp_frame);
        tick();
        chk("m_done_once", done, 0);
        chk("m_idle_busy", busy, 0);
    endtask

    typedef struct {
        logic [4:0] len;
        logic [7:0] loop;
        int         exp_cnt;
        logic       exp_busy;
        int         exp_done;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        vecs[0] = '{5'd3,  8'd1,   3,   1'b1, 1};
        vecs[1] = '{5'd2,  8'd3,   6,   1'b1, 1};
        vecs[2] = '{5'd2,  8'd0,   2,   1'b1, 1};
        vecs[3] = '{5'd0,  8'd1,   0,   1'b0, 0};
        vecs[4] = '{5'd17, 8'd1,   0,   1'b0, 0};
        vecs[5] = '{5'd16, 8'd1,   16,  1'b1, 1};
        vecs[6] = '{5'd1,  8'd4,   4,   1'b1, 1};
        vecs[7] = '{5'd2,  8'd255, 510, 1'b1, 1};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_waddr = '0; cfg_wdata = '0;
        start = 1'b0; ctx_len = '0; loop_cnt = '0; stall = 1'b0; abort = 1'b0;
        exp_frame = '0; exp_idx = '0;
        repeat (2) tick();
        chk("rst_valid", config_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_frame", config_frame, 0);
        chk("rst_idx", cur_idx, 0);
        rst_n = 1'b1;
        tick();

        wr(0, 64'h1111_0000_0000_0001);
        wr(1, 64'h2222_0000_0000_0003);
        wr(2, 64'h3333_0000_0000_0010);
        for (int i = 3; i < 16; i++)
            wr(i, {8'hC0, 8'(i), 40'h5A_0000_0000, 8'(i)});

        // Table of run requests: count issued frames, order, gaps, done pulse.
        for (int k = 0; k < NV; k++) begin
            int L, n, dn, first, last;
            L = int'(vecs[k].len);
            n = 0; dn = 0; first = -1; last = -1;
            ctx_len  = vecs[k].len;
            loop_cnt = vecs[k].loop;
            start    = 1'b1;
            tick();
            start    = 1'b0;
            chk("t_busy_after_start", busy, vecs[k].exp_busy);
            chk("t_bubble", config_valid, 0);
            for (int c = 0; c < vecs[k].exp_cnt + 8; c++) begin
                tick();
                if (config_valid) begin
                    if (first < 0) first = c;
                    last = c;
                    chk("t_frame", config_frame, shadow[n % L]);
                    chk("t_idx", cur_idx, 64'(n % L));
                    n++;
                end
                if (done) begin
                    dn++;
                    chk("t_busy_at_done", busy, 0);
                    chk("t_done_after_last", 64'(c), 64'(last + 1));
                    break;
                end
            end
            chk("t_count", 64'(n), 64'(vecs[k].exp_cnt));
            chk("t_done_count", 64'(dn), 64'(vecs[k].exp_done));
            if (n > 0) begin
                chk("t_first_latency", 64'(first), 0);
                chk("t_no_bubbles", 64'(last - first + 1), 64'(n));
                exp_frame = shadow[(n - 1) % L];
                exp_idx   = 4'((n - 1) % L);
            end
            tick();
            chk("t_idle_busy", busy, 0);
        end

        // Stall for two cycles after F0 issues.
        ctx_len = 5'd3; loop_cnt = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("s_f0_valid", config_valid, 1);
        chk("s_f0", config_frame, shadow[0]);
        stall = 1'b1;
        tick();
        chk("s_stall1_valid", config_valid, 0);
        chk("s_stall1_hold", config_frame, shadow[0]);
        tick();
        chk("s_stall2_valid", config_valid, 0);
        chk("s_stall2_idx", cur_idx, 0);
        stall = 1'b0;
        tick();
        chk("s_f1", config_frame, shadow[1]);
        chk("s_f1_idx", cur_idx, 1);
        tick();
        chk("s_f2", config_frame, shadow[2]);
        chk("s_f2_valid", config_valid, 1);
        tick();
        chk("s_done", done, 1);
        chk("s_done_valid", config_valid, 0);
        tick();
        exp_frame = shadow[2]; exp_idx = 4'd2;

        // Abort after F1; a context write during the run must be ignored.
        ctx_len = 5'd3; loop_cnt = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        cfg_we = 1'b1; cfg_waddr = 4'd0; cfg_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        cfg_we = 1'b0;
        chk("a_f0", config_frame, shadow[0]);
        tick();
        chk("a_f1", config_frame, shadow[1]);
        abort = 1'b1; stall = 1'b1;
        tick();
        abort = 1'b0; stall = 1'b0;
        chk("a_valid", config_valid, 0);
        chk("a_busy", busy, 0);
        chk("a_frame_hold", config_frame, shadow[1]);
        for (int c = 0; c < 3; c++) begin
            chk("a_no_done", done, 0);
            tick();
        end
        exp_frame = shadow[1]; exp_idx = 4'd1;
        run_model(1, 1, 0, -1);

        // Asynchronous reset between clock edges mid-run.
        ctx_len = 5'd3; loop_cnt = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("r_running", config_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_valid", config_valid, 0);
        chk("r_busy", busy, 0);
        chk("r_frame", config_frame, 0);
        chk("r_idx", cur_idx, 0);
        tick();
        rst_n = 1'b1;
        exp_frame = '0; exp_idx = '0;
        tick();
        run_model(2, 1, 30, -1);

`ifdef CGRA_CTX_PARITY_EN
        // Single-bit flip in entry 1: F0 issues, F1 is refused.
        dut.u_mem.mem_q[1] = dut.u_mem.mem_q[1] ^ 65'h1_0000;
        ctx_len = 5'd3; loop_cnt = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("p_f0", config_frame, shadow[0]);
        tick();
        chk("p_valid", config_valid, 0);
        chk("p_err", err, 1);
        chk("p_busy", busy, 0);
        chk("p_frame_hold", config_frame, shadow[0]);
        tick();
        chk("p_no_done", done, 0);
        chk("p_err_sticky", err, 1);
        wr(1, shadow[1]);
        exp_frame = shadow[0]; exp_idx = 4'd0;
        run_model(3, 1, 0, -1);
        chk("p_err_cleared", err, 0);
`endif

        // Randomized runs with random stalls, reloads and occasional aborts.
        for (int t = 0; t < 30; t++) begin
            int len, loop, total, ab;
            if ($urandom_range(0, 1) == 1) begin
                wr(int'($urandom_range(0, 15)), {$urandom(), $urandom()});
                wr(int'($urandom_range(0, 15)), {$urandom(), $urandom()});
            end
            len   = int'($urandom_range(1, 16));
            loop  = int'($urandom_range(0, 4));
            total = len * ((loop == 0) ? 1 : loop);
            ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 1)) : -1;
            run_model(len, loop, int'($urandom_range(0, 60)), ab);
        end
        chk("end_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
